// File: rtl/div32_seq.sv
// Sequential restoring divider: LO = A / B, HI = A % B, one quotient bit per clock.
// Optional macro DIV32_EARLY_TERM_EN: B==0 or A<B completes on the accepting edge.
module div32_seq #(
   parameter int WIDTH = 32,
   parameter int CNT_W = 6
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic             i_start,
   input  logic [WIDTH-1:0] i_a,
   input  logic [WIDTH-1:0] i_b,
   output logic             o_busy,
   output logic             o_done,
   output logic [WIDTH-1:0] o_hi,
   output logic [WIDTH-1:0] o_lo
);

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

   state_t           r_state, w_next;
   logic [WIDTH-1:0] r_q, r_d, r_r, r_hi, r_lo;
   logic [CNT_W-1:0] r_cnt;

   logic             w_accept, w_early, w_last, w_ge;
   logic [WIDTH:0]   w_rs, w_diff;
   logic [WIDTH-1:0] w_rem, w_quo;

   assign w_accept = i_start && (r_state != S_RUN);
   assign w_last   = (r_cnt == CNT_W'(WIDTH-1));

`ifdef DIV32_EARLY_TERM_EN
   assign w_early = (i_b == '0) || (i_a < i_b);
`else
   assign w_early = 1'b0;
`endif

   // Partial remainder stays below D, so the shifted value fits WIDTH+1 bits and
   // the top bit of the difference is a clean borrow (no-borrow means R' >= D).
   assign w_rs   = {r_r, r_q[WIDTH-1]};
   assign w_diff = w_rs - {1'b0, r_d};
   assign w_ge   = ~w_diff[WIDTH];
   assign w_rem  = w_ge ? w_diff[WIDTH-1:0] : w_rs[WIDTH-1:0];
   assign w_quo  = {r_q[WIDTH-2:0], w_ge};

   always_ff @(posedge i_clk) begin
      if (i_rst) r_state <= S_IDLE;
      else       r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE: if (w_accept) w_next = w_early ? S_DONE : S_RUN;
         S_RUN:  if (w_last)   w_next = S_DONE;
         S_DONE: begin
            if (w_accept) w_next = w_early ? S_DONE : S_RUN;
            else          w_next = S_IDLE;
         end
         default: w_next = S_IDLE;
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_q   <= '0;
         r_d   <= '0;
         r_r   <= '0;
         r_cnt <= '0;
         r_hi  <= '0;
         r_lo  <= '0;
      end else if (w_accept) begin
         r_q   <= i_a;
         r_d   <= i_b;
         r_r   <= '0;
         r_cnt <= '0;
         if (w_early) begin
            r_hi <= i_a;
            r_lo <= (i_b == '0) ? '1 : '0;
         end
      end else if (r_state == S_RUN) begin
         r_r   <= w_rem;
         r_q   <= w_quo;
         r_cnt <= r_cnt + CNT_W'(1);
         if (w_last) begin
            r_hi <= w_rem;
            r_lo <= w_quo;
         end
      end
   end

   assign o_busy = (r_state == S_RUN);
   assign o_done = (r_state == S_DONE);
   assign o_hi   = r_hi;
   assign o_lo   = r_lo;

endmodule
